// File: rtl/elevator_car_motion_ctrl.sv
// Car motion/door sequencer: owns floor and direction, times travel and door dwell, pulses queue clears.
// Latency: door opens 1 cycle after an at-floor request; each floor moved costs TRAVEL_CYCLES+1 cycles.
// No backpressure: clear_valid is a one-shot pulse. Define ELEV_DOOR_HOLD_EN to add door_hold.
module elevator_car_motion_ctrl #(
    parameter int NUM_FLOORS    = 7,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] queue_status,
    input  logic                  queue_empty,
    input  logic                  next_up_ndown,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  current_up_ndown,
    output logic                  moving,
    output logic                  door_open,
    output logic                  clear_valid,
    output logic [FLOOR_W-1:0]    clear_floor
);

    localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAVEL,
        S_ARRIVE,
        S_DOOR_OPEN,
        S_DOOR_CLOSE
    } state_t;

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [FLOOR_W-1:0]   floor_n;
    logic                 dir_n;
    logic                 clear_n;
    logic                 req_here;
    logic                 at_limit;
    logic                 hold;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign req_here = queue_status[current_floor];
    assign at_limit = current_up_ndown ? (current_floor == TOP_FLOOR)
                                       : (current_floor == '0);

    always_comb begin
        state_n = state;
        timer_n = timer;
        floor_n = current_floor;
        dir_n   = current_up_ndown;
        clear_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_here) begin
                    state_n = S_DOOR_OPEN;
                    timer_n = DOOR_LOAD;
                    clear_n = 1'b1;
                end else if (!queue_empty) begin
                    dir_n   = next_up_ndown;
                    timer_n = TRAVEL_LOAD;
                    state_n = S_TRAVEL;
                end
            end
            S_TRAVEL: begin
                if (timer == '0) begin
                    // A step past the shaft ends is refused; the resolver re-decides from IDLE.
                    if (at_limit) begin
                        state_n = S_IDLE;
                    end else begin
                        floor_n = current_up_ndown ? current_floor + FLOOR_W'(1)
                                                   : current_floor - FLOOR_W'(1);
                        state_n = S_ARRIVE;
                    end
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            S_ARRIVE: begin
                if (req_here) begin
                    state_n = S_DOOR_OPEN;
                    timer_n = DOOR_LOAD;
                    clear_n = 1'b1;
                end else if (queue_empty) begin
                    state_n = S_IDLE;
                end else if (next_up_ndown == current_up_ndown) begin
                    timer_n = TRAVEL_LOAD;
                    state_n = S_TRAVEL;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DOOR_OPEN: begin
                // While clear_valid is high the queue bit is still the one being cleared.
                clear_n = req_here && !clear_valid;
                if (clear_n || hold) begin
                    timer_n = DOOR_LOAD;
                end else if (timer == '0) begin
                    state_n = S_DOOR_CLOSE;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            S_DOOR_CLOSE: begin
                if (hold) begin
                    state_n = S_DOOR_OPEN;
                    timer_n = DOOR_LOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            timer            <= '0;
            current_floor    <= '0;
            current_up_ndown <= 1'b1;
            moving           <= 1'b0;
            door_open        <= 1'b0;
            clear_valid      <= 1'b0;
            clear_floor      <= '0;
        end else begin
            state            <= state_n;
            timer            <= timer_n;
            current_floor    <= floor_n;
            current_up_ndown <= dir_n;
            moving           <= (state_n == S_TRAVEL);
            door_open        <= (state_n == S_DOOR_OPEN);
            clear_valid      <= clear_n;
            if (clear_n) begin
                clear_floor <= current_floor;
            end
        end
    end

endmodule

// File: tb/tb_elevator_car_motion_ctrl.sv
// Directed bench for elevator_car_motion_ctrl with a scoreboard of expected clear floors.
module tb_elevator_car_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] queue_status;
    logic       queue_empty;
    logic       next_up_ndown;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif
    logic [2:0] current_floor;
    logic       current_up_ndown;
    logic       moving;
    logic       door_open;
    logic       clear_valid;
    logic [2:0] clear_floor;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    elevator_car_motion_ctrl #(
        .NUM_FLOORS(7),
        .FLOOR_W(3),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .queue_status(queue_status),
        .queue_empty(queue_empty),
        .next_up_ndown(next_up_ndown),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .current_floor(current_floor),
        .current_up_ndown(current_up_ndown),
        .moving(moving),
        .door_open(door_open),
        .clear_valid(clear_valid),
        .clear_floor(clear_floor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every wait goes through here so clear pulses and exclusivity are always monitored.
    task automatic tick();
        int e;
        @(negedge clk);
        check("moving_and_door", {31'd0, moving & door_open}, 0);
        if (clear_valid) begin
            if (exp_q.size() == 0) begin
                check("clear_unexpected", {31'd0, clear_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("clear_floor", {29'd0, clear_floor}, e);
            end
        end
    endtask

    task automatic step_to(input int exp_floor, input int exp_cycles, input string tag);
        int n = 0;
        logic [2:0] f0 = current_floor;
        do begin
            tick();
            n++;
        end while (current_floor == f0 && n < 60);
        check({tag, "_floor"}, {29'd0, current_floor}, exp_floor);
        check({tag, "_spacing"}, n, exp_cycles);
    endtask

    task automatic check_dwell(input int exp_n, input string tag);
        int n = 0;
        while (door_open && n < 100) begin
            n++;
            tick();
        end
        check(tag, n, exp_n);
    endtask

    initial begin
        logic [3:0] acc;
        int n;
        rst           = 1'b1;
        queue_status  = '0;
        queue_empty   = 1'b1;
        next_up_ndown = 1'b1;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold     = 1'b0;
`endif
        // Reset state
        tick();
        tick();
        check("rst_floor", {29'd0, current_floor}, 0);
        check("rst_dir", {31'd0, current_up_ndown}, 1);
        check("rst_moving", {31'd0, moving}, 0);
        check("rst_door", {31'd0, door_open}, 0);
        check("rst_clear_valid", {31'd0, clear_valid}, 0);
        check("rst_clear_floor", {29'd0, clear_floor}, 0);
        rst = 1'b0;

        // Empty queue: car stays put
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc |= {moving, door_open, clear_valid, |current_floor};
        end
        check("idle_hold", {28'd0, acc}, 0);

        // Request at the idle floor
        queue_status = 7'b0000001;
        queue_empty  = 1'b0;
        exp_q.push_back(0);
        tick();
        check("here_door", {31'd0, door_open}, 1);
        check("here_moving", {31'd0, moving}, 0);
        queue_status = '0;
        queue_empty  = 1'b1;
        check_dwell(3, "here_dwell");
        check("here_close_moving", {31'd0, moving}, 0);
        tick();

        // Travel up, reversal at floor 3, back down to floor 1
        queue_status = 7'b0100000;
        queue_empty  = 1'b0;
        step_to(1, 5, "rev_up1");
        step_to(2, 5, "rev_up2");
        step_to(3, 5, "rev_up3");
        queue_status  = 7'b0000010;
        next_up_ndown = 1'b0;
        exp_q.push_back(1);
        tick();
        check("rev_idle_dir", {31'd0, current_up_ndown}, 1);
        check("rev_idle_moving", {31'd0, moving}, 0);
        tick();
        check("rev_new_dir", {31'd0, current_up_ndown}, 0);
        check("rev_moving", {31'd0, moving}, 1);
        step_to(2, 4, "rev_dn2");
        step_to(1, 5, "rev_dn1");
        tick();
        check("rev_door", {31'd0, door_open}, 1);
        queue_status = '0;
        queue_empty  = 1'b1;
        check_dwell(3, "rev_dwell");
        tick();

        // Reset in the middle of a floor-to-floor move
        queue_status  = 7'b0100000;
        queue_empty   = 1'b0;
        next_up_ndown = 1'b1;
        step_to(2, 5, "abort_up2");
        tick();
        tick();
        check("abort_pre_moving", {31'd0, moving}, 1);
        rst = 1'b1;
        tick();
        check("abort_floor", {29'd0, current_floor}, 0);
        check("abort_moving", {31'd0, moving}, 0);
        check("abort_clear", {31'd0, clear_valid}, 0);
        check("abort_dir", {31'd0, current_up_ndown}, 1);
        rst          = 1'b0;
        queue_status = '0;
        queue_empty  = 1'b1;
        tick();

        // Floor 0 to floor 3 with service
        queue_status = 7'b0001000;
        queue_empty  = 1'b0;
        exp_q.push_back(3);
        step_to(1, 5, "run_f1");
        step_to(2, 5, "run_f2");
        step_to(3, 5, "run_f3");
        tick();
        check("run_door", {31'd0, door_open}, 1);
        check("run_clear_valid", {31'd0, clear_valid}, 1);
        queue_status = '0;
        queue_empty  = 1'b1;
        check_dwell(3, "run_dwell");
        tick();
        check("run_idle_door", {31'd0, door_open}, 0);
        check("run_idle_moving", {31'd0, moving}, 0);
        check("run_idle_floor", {29'd0, current_floor}, 3);

`ifdef ELEV_DOOR_HOLD_EN
        // Door held for 10 cycles extends dwell without a second clear
        queue_status = 7'b0001000;
        queue_empty  = 1'b0;
        exp_q.push_back(3);
        tick();
        queue_status = '0;
        queue_empty  = 1'b1;
        door_hold    = 1'b1;
        n = 0;
        while (door_open && n < 100) begin
            n++;
            if (n == 11) door_hold = 1'b0;
            tick();
        end
        door_hold = 1'b0;
        check("hold_dwell", n, 13);
        tick();
`endif

        check("clear_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
